fpga_robots_game_tm_cmd: RTL

//  Tile-map command engine. Sits upstream of fpga_robots_game_video and drives its external tile map port (tm_adr/tm_wrt/tm_wen/tm_red).

---
 rtl/fpga_robots_game_tm_cmd_pkg.sv | 40 ++++
 rtl/fpga_robots_game_tm_walker.sv | 80 ++++++++
 rtl/fpga_robots_game_tm_cmd.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fpga_robots_game_tm_cmd_pkg.sv
// Shared definitions for the tile-map command engine: op codes, FSM encodings,
// tile map geometry and small datapath helpers.
package fpga_robots_game_tm_cmd_pkg;

    localparam int TM_COLS     = 128;
    localparam int TM_VIS_ROWS = 48;
    localparam int TM_ADR_W    = 13;

    localparam logic [1:0] TMCMD_FILL  = 2'd0;
    localparam logic [1:0] TMCMD_RMW   = 2'd1;
    localparam logic [1:0] TMCMD_COUNT = 2'd2;
    localparam logic [1:0] TMCMD_NOP   = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_RD    = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_CNT   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] mask;
    } cmd_t;

    function automatic logic [7:0] rmw_merge(input logic [7:0] old_v,
                                             input logic [7:0] ins_v,
                                             input logic [7:0] mask_v);
        return (old_v & ~mask_v) | (ins_v & mask_v);
    endfunction

    function automatic logic masked_hit(input logic [7:0] rd_v,
                                        input logic [7:0] data_v,
                                        input logic [7:0] mask_v);
        return (rd_v & mask_v) == (data_v & mask_v);
    endfunction

endpackage

// File: rtl/fpga_robots_game_tm_walker.sv
// Rectangle walker: column-fastest scan of a tile map rectangle, wrapping
// column mod 2^COL_W and row mod 2^ROW_W, with a last-byte flag.
module fpga_robots_game_tm_walker #(
    parameter int COL_W = 7,
    parameter int ROW_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   step,
    input  logic [COL_W-1:0]       start_col,
    input  logic [ROW_W-1:0]       start_row,
    input  logic [COL_W-1:0]       w,
    input  logic [ROW_W-1:0]       h,
    output logic [ROW_W+COL_W-1:0] adr,
    output logic                   last
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] x_q, x_d;
    logic [ROW_W-1:0] y_q, y_d;
    logic [COL_W-1:0] base_col_q, base_col_d;
    logic [COL_W-1:0] w_q, w_d;
    logic [ROW_W-1:0] h_q, h_d;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        x_d        = x_q;
        y_d        = y_q;
        base_col_d = base_col_q;
        w_d        = w_q;
        h_d        = h_q;
        if (start) begin
            col_d      = start_col;
            row_d      = start_row;
            x_d        = '0;
            y_d        = '0;
            base_col_d = start_col;
            w_d        = w;
            h_d        = h;
        end else if (step) begin
            // x/y count progress inside the rectangle; col/row are the wrapped address.
            if (x_q == w_q) begin
                x_d   = '0;
                col_d = base_col_q;
                y_d   = y_q + 1'b1;
                row_d = row_q + 1'b1;
            end else begin
                x_d   = x_q + 1'b1;
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            base_col_q <= '0;
            w_q        <= '0;
            h_q        <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            x_q        <= x_d;
            y_q        <= y_d;
            base_col_q <= base_col_d;
            w_q        <= w_d;
            h_q        <= h_d;
        end
    end

    assign adr  = {row_q, col_q};
    assign last = (x_q == w_q) && (y_q == h_q);

endmodule

// File: rtl/fpga_robots_game_tm_cmd.sv
// Tile-map command engine: FILL, masked RMW and masked COUNT over a rectangle.
// Define FPGA_ROBOTS_TMCMD_VBI_GATE_EN to restrict tile map accesses to vbi=1 cycles.
module fpga_robots_game_tm_cmd
    import fpga_robots_game_tm_cmd_pkg::*;
#(
    parameter int COL_W = 7,
    parameter int ROW_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [COL_W-1:0]       cmd_col,
    input  logic [ROW_W-1:0]       cmd_row,
    input  logic [COL_W-1:0]       cmd_w,
    input  logic [ROW_W-1:0]       cmd_h,
    input  logic [7:0]             cmd_data,
    input  logic [7:0]             cmd_mask,
    output logic                   busy,
    output logic                   done,
    output logic [ROW_W+COL_W-1:0] count,
    output logic [ROW_W+COL_W-1:0] tm_adr,
    output logic [7:0]             tm_wrt,
    output logic                   tm_wen,
    input  logic [7:0]             tm_red,
    input  logic                   vbi,
    output logic [2:0]             dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_* need only be stable in that cycle.

    logic [2:0]             state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [ROW_W+COL_W-1:0] count_q, count_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [7:0]             red_q, red_d;
    logic [7:0]             rd_now;
    logic                   accept;
    logic                   go;
    logic                   walk_start;
    logic                   walk_step;
    logic                   walk_last;

`ifdef FPGA_ROBOTS_TMCMD_VBI_GATE_EN
    assign go = vbi;
`else
    logic unused_vbi;
    assign unused_vbi = vbi;
    assign go = 1'b1;
`endif

    assign accept     = cmd_valid && (state_q == ST_IDLE);
    assign walk_start = accept && (cmd_op != TMCMD_NOP);

    fpga_robots_game_tm_walker #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .start     (walk_start),
        .step      (walk_step),
        .start_col (cmd_col),
        .start_row (cmd_row),
        .w         (cmd_w),
        .h         (cmd_h),
        .adr       (tm_adr),
        .last      (walk_last)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        count_d   = count_q;
        rd_pend_d = 1'b0;
        red_d     = red_q;
        walk_step = 1'b0;
        tm_wen    = 1'b0;
        tm_wrt    = 8'h00;
        // Read data arrives the cycle after issue; keep a copy in case the write stalls.
        rd_now    = rd_pend_q ? tm_red : red_q;
        if (rd_pend_q) begin
            red_d = tm_red;
            if (cmd_q.op == TMCMD_COUNT && masked_hit(tm_red, cmd_q.data, cmd_q.mask)) begin
                count_d = count_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d   = '{op: cmd_op, data: cmd_data, mask: cmd_mask};
                    count_d = '0;
                    case (cmd_op)
                        TMCMD_FILL:  state_d = ST_FILL;
                        TMCMD_RMW:   state_d = ST_RD;
                        TMCMD_COUNT: state_d = ST_CNT;
                        default:     state_d = ST_DONE;
                    endcase
                end
            end
            ST_FILL: begin
                tm_wrt = cmd_q.data;
                if (go) begin
                    tm_wen = 1'b1;
                    if (walk_last) state_d = ST_DONE;
                    else           walk_step = 1'b1;
                end
            end
            ST_RD: begin
                if (go) begin
                    rd_pend_d = 1'b1;
                    state_d   = ST_WR;
                end
            end
            ST_WR: begin
                tm_wrt = rmw_merge(rd_now, cmd_q.data, cmd_q.mask);
                if (go) begin
                    tm_wen = 1'b1;
                    if (walk_last) begin
                        state_d = ST_DONE;
                    end else begin
                        walk_step = 1'b1;
                        state_d   = ST_RD;
                    end
                end
            end
            ST_CNT: begin
                if (go) begin
                    rd_pend_d = 1'b1;
                    if (walk_last) state_d = ST_DRAIN;
                    else           walk_step = 1'b1;
                end
            end
            // The final read is always pending here, so its compare completes this cycle.
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            red_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
            red_q     <= red_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign done      = (state_q == ST_DONE);
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule
